mips_decode_execute: RTL and testbench

- Single-cycle MIPS decode/execute slice: main and ALU decoder, ALU source-B mux, and 32-bit ALU in one block.
- Sits between the register file and the PC/data-memory logic.
- Control outputs, srcb, alu_result and zero are combinational in the same cycle as the inputs.
- One registered stage captures the ALU status and a sticky illegal-instruction flag.

---
 rtl/mips_decode_execute.sv | 129 ++++++++++++
 tb/tb_mips_decode_execute.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mips_decode_execute.sv
// Single-cycle MIPS decode/execute slice: main/ALU decoders, srcB mux, ALU and status register.
// Optional macro ADDI_EN adds decode support for addi (op 001000).
module mips_decode_execute #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    input  logic [WIDTH-1:0] sign_imm,
    output logic             memtoreg,
    output logic             memwrite,
    output logic             branch,
    output logic             alusrc,
    output logic             regdst,
    output logic             regwrite,
    output logic [2:0]       alucontrol,
    output logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic [WIDTH-1:0] result_q,
    output logic             zero_q,
    output logic             illegal_q
);

    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALUOP_W = 2;

    typedef struct packed {
        logic               memtoreg;
        logic               memwrite;
        logic               branch;
        logic               alusrc;
        logic               regdst;
        logic               regwrite;
        logic [ALUOP_W-1:0] aluop;
    } ctrl_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
`ifdef ADDI_EN
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
`endif

    ctrl_t ctrl;
    logic  op_illegal;
    logic  funct_illegal;

    // Main decoder: unknown opcodes drive all controls low and flag illegal.
    always_comb begin
        ctrl       = '0;
        op_illegal = 1'b0;
        case (op)
            OP_RTYPE: ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10};
            OP_LW:    ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
            OP_SW:    ctrl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
            OP_BEQ:   ctrl = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01};
`ifdef ADDI_EN
            OP_ADDI:  ctrl = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
`endif
            default:  op_illegal = 1'b1;
        endcase
    end

    // ALU decoder: an unsupported funct also suppresses the register write.
    always_comb begin
        alucontrol    = 3'b010;
        funct_illegal = 1'b0;
        case (ctrl.aluop)
            2'b00: alucontrol = 3'b010;
            2'b01: alucontrol = 3'b110;
            2'b10: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default: begin
                        alucontrol    = 3'b000;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

    assign memtoreg = ctrl.memtoreg;
    assign memwrite = ctrl.memwrite;
    assign branch   = ctrl.branch;
    assign alusrc   = ctrl.alusrc;
    assign regdst   = ctrl.regdst;
    assign regwrite = ctrl.regwrite & ~funct_illegal;

    assign srcb = ctrl.alusrc ? sign_imm : rd2;

    always_comb begin
        alu_result = '0;
        case (alucontrol)
            3'b000:  alu_result = rd1 & srcb;
            3'b001:  alu_result = rd1 | srcb;
            3'b010:  alu_result = rd1 + srcb;
            3'b110:  alu_result = rd1 - srcb;
            3'b111:  alu_result = ($signed(rd1) < $signed(srcb)) ? WIDTH'(1) : '0;
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // Status stage; illegal_q is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            result_q  <= alu_result;
            zero_q    <= zero;
            illegal_q <= illegal_q | op_illegal | funct_illegal;
        end
    end

endmodule

// File: tb/tb_mips_decode_execute.sv
// Directed bench for mips_decode_execute; expectations are hand-computed constants.
module tb_mips_decode_execute;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       op;
    logic [5:0]       funct;
    logic [WIDTH-1:0] rd1, rd2, sign_imm;
    logic             memtoreg, memwrite, branch, alusrc, regdst, regwrite;
    logic [2:0]       alucontrol;
    logic [WIDTH-1:0] srcb, alu_result, result_q;
    logic             zero, zero_q, illegal_q;

    int n_checks = 0;
    int n_pass   = 0;

    mips_decode_execute #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct),
        .rd1(rd1), .rd2(rd2), .sign_imm(sign_imm),
        .memtoreg(memtoreg), .memwrite(memwrite), .branch(branch),
        .alusrc(alusrc), .regdst(regdst), .regwrite(regwrite),
        .alucontrol(alucontrol), .srcb(srcb), .alu_result(alu_result),
        .zero(zero), .result_q(result_q), .zero_q(zero_q), .illegal_q(illegal_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Apply inputs on the falling edge so combinational outputs settle before the next rise.
    task automatic drive(input logic [5:0] o, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        @(negedge clk);
        op = o; funct = f; rd1 = a; rd2 = b; sign_imm = imm;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string tag, input logic [5:0] exp);
        check(tag, {26'd0, memtoreg, memwrite, branch, alusrc, regdst, regwrite}, {26'd0, exp});
    endtask

    initial begin
        reset = 1'b1;
        op = '0; funct = 6'b100000; rd1 = '0; rd2 = '0; sign_imm = '0;

        // Combinational path keeps working while reset is held.
        drive(6'b000000, 6'b100000, 32'd3, 32'd4, 32'd0);
        check("comb_in_reset", alu_result, 32'd7);
        tick();
        check("rst_result_q", result_q, 32'd0);
        check("rst_zero_q", {31'd0, zero_q}, 32'd0);
        check("rst_illegal_q", {31'd0, illegal_q}, 32'd0);
        @(negedge clk); reset = 1'b0;

        // R-type add
        drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
        check_ctrl("radd_ctrl", 6'b000011);
        check("radd_aluctl", {29'd0, alucontrol}, 32'd2);
        check("radd_res", alu_result, 32'd12);
        check("radd_zero", {31'd0, zero}, 32'd0);
        tick();
        check("radd_result_q", result_q, 32'd12);
        check("radd_illegal_q", {31'd0, illegal_q}, 32'd0);

        // beq with equal operands
        drive(6'b000100, 6'b000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0000_0010);
        check_ctrl("beq_ctrl", 6'b001000);
        check("beq_aluctl", {29'd0, alucontrol}, 32'd6);
        check("beq_res", alu_result, 32'd0);
        check("beq_zero", {31'd0, zero}, 32'd1);
        tick();
        check("beq_zero_q", {31'd0, zero_q}, 32'd1);

        // lw address generation with negative offset
        drive(6'b100011, 6'b000000, 32'd100, 32'd999, 32'hFFFFFFFC);
        check_ctrl("lw_ctrl", 6'b100101);
        check("lw_srcb", srcb, 32'hFFFFFFFC);
        check("lw_res", alu_result, 32'd96);

        // sw
        drive(6'b101011, 6'b000000, 32'h1000, 32'd5, 32'h0000_0008);
        check_ctrl("sw_ctrl", 6'b010100);
        check("sw_res", alu_result, 32'h1008);

        // slt signed, both directions
        drive(6'b000000, 6'b101010, 32'hFFFFFFFF, 32'd1, 32'd0);
        check("slt_aluctl", {29'd0, alucontrol}, 32'd7);
        check("slt_neg_lt", alu_result, 32'd1);
        drive(6'b000000, 6'b101010, 32'd1, 32'hFFFFFFFF, 32'd0);
        check("slt_pos_ge", alu_result, 32'd0);
        check("slt_zero", {31'd0, zero}, 32'd1);

        // add wraps modulo 2^32
        drive(6'b000000, 6'b100000, 32'hFFFFFFFF, 32'd1, 32'd0);
        check("wrap_res", alu_result, 32'd0);
        check("wrap_zero", {31'd0, zero}, 32'd1);

        // sub, and, or
        drive(6'b000000, 6'b100010, 32'd10, 32'd3, 32'd0);
        check("sub_res", alu_result, 32'd7);
        drive(6'b000000, 6'b100010, 32'd3, 32'd10, 32'd0);
        check("sub_wrap", alu_result, 32'hFFFFFFF9);
        drive(6'b000000, 6'b100100, 32'h0000F0F0, 32'h0000FF00, 32'd0);
        check("and_res", alu_result, 32'h0000F000);
        check("and_aluctl", {29'd0, alucontrol}, 32'd0);
        drive(6'b000000, 6'b100101, 32'h0000F0F0, 32'h00000F00, 32'd0);
        check("or_res", alu_result, 32'h0000FFF0);
        check("or_aluctl", {29'd0, alucontrol}, 32'd1);
        tick();
        check("legal_illegal_q", {31'd0, illegal_q}, 32'd0);

        // addi: decoded only when the optional feature is built in
        drive(6'b001000, 6'b000000, 32'd10, 32'd0, 32'hFFFFFFFE);
`ifdef ADDI_EN
        check_ctrl("addi_ctrl", 6'b000101);
        check("addi_res", alu_result, 32'd8);
        tick();
        check("addi_illegal_q", {31'd0, illegal_q}, 32'd0);
`else
        check_ctrl("addi_ctrl", 6'b000000);
        check("addi_res", alu_result, 32'd10);
        tick();
        check("addi_illegal_q", {31'd0, illegal_q}, 32'd1);
`endif

        @(negedge clk); reset = 1'b1;
        tick();
        check("rst2_illegal_q", {31'd0, illegal_q}, 32'd0);
        @(negedge clk); reset = 1'b0;

        // Unsupported funct: regwrite forced low, and-code, sticky flag sets
        drive(6'b000000, 6'b000111, 32'h0000_00FF, 32'h0000_0F0F, 32'd0);
        check_ctrl("badf_ctrl", 6'b000010);
        check("badf_aluctl", {29'd0, alucontrol}, 32'd0);
        check("badf_res", alu_result, 32'h0000_000F);
        tick();
        check("badf_illegal_q", {31'd0, illegal_q}, 32'd1);

        @(negedge clk); reset = 1'b1;
        tick();
        @(negedge clk); reset = 1'b0;

        // Unknown opcode
        drive(6'b111111, 6'b100000, 32'd1, 32'd2, 32'd3);
        check_ctrl("badop_ctrl", 6'b000000);
        check("badop_aluctl", {29'd0, alucontrol}, 32'd2);
        check("badop_res", alu_result, 32'd3);
        tick();
        check("badop_illegal_q", {31'd0, illegal_q}, 32'd1);

        // Sticky across a legal instruction
        drive(6'b000000, 6'b100000, 32'd5, 32'd7, 32'd0);
        tick();
        check("sticky_illegal_q", {31'd0, illegal_q}, 32'd1);
        check("sticky_result_q", result_q, 32'd12);

        // One-edge reset clears all registered status
        @(negedge clk); reset = 1'b1;
        tick();
        check("rst3_result_q", result_q, 32'd0);
        check("rst3_zero_q", {31'd0, zero_q}, 32'd0);
        check("rst3_illegal_q", {31'd0, illegal_q}, 32'd0);
        check("rst3_comb", alu_result, 32'd12);
        @(negedge clk); reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
